uart_rx_sync: RTL

8N1 UART receiver that sits directly upstream of the authentication state machine. It synchronizes the raw RX pin from the Bluetooth module and recovers bytes by mid-bit sampling. It presents each byte on rx_data with a rdy flag that the consumer clears through clr_rdy. It also reports framing errors and overruns as single-cycle pulses for debug and telemetry.

---
 rtl/uart_rx_sync_if.sv | 20 ++
 rtl/uart_rx_sync.sv | 121 ++++++++++++
 2 files changed

// File: rtl/uart_rx_sync_if.sv
// Byte-side and line-side signals of the 8N1 receiver, bundled for port connection.
// The master side drives the serial line and the acknowledge; the slave is the receiver.
interface uart_rx_sync_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output RX, clr_rdy,
    input  rx_data, rdy, frame_err, overrun
  );

  modport slave (
    input  RX, clr_rdy,
    output rx_data, rdy, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_sync.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling,
// held byte with rdy/clr_rdy handshake, single-cycle frame_err and overrun pulses.
module uart_rx_sync #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_sync_if.slave bus
);
  localparam int unsigned CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_LD = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          fall;
  logic          tick;

  // prev_q holds the synced value from the cycle before, so a steady low never retriggers
  assign fall = prev_q & ~sync2_q;
  assign tick = (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync1_q <= bus.RX;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q & ~bus.clr_rdy;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          cnt_d   = HALF_LD;
          state_d = START;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (sync2_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = BAUD_LD;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = BAUD_LD;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          if (sync2_q) begin
            // a set coinciding with clr_rdy wins and is not an overrun
            data_d = shift_q;
            rdy_d  = 1'b1;
            ov_d   = rdy_q & ~bus.clr_rdy;
          end else begin
            fe_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ov_q;
endmodule
